// File: rtl/knockout_pkg.sv
// Shared types and constants for the 4-player knockout bracket sequencer.
package knockout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEMI1 = 3'd1,
    ST_SEMI2 = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MATCH_SEMI1 = 2'd0;
  localparam logic [1:0] MATCH_SEMI2 = 2'd1;
  localparam logic [1:0] MATCH_FINAL = 2'd2;

  localparam logic [1:0] PLAYER_0 = 2'd0;
  localparam logic [1:0] PLAYER_1 = 2'd1;
  localparam logic [1:0] PLAYER_2 = 2'd2;
  localparam logic [1:0] PLAYER_3 = 2'd3;

  localparam int SCORE_W = 3;

  // Same function as the bracket mux fed with player IDs 0..3.
  function automatic logic [1:0] bracket_pick(input logic sel0, input logic sel1,
                                              input logic sel2);
    return sel2 ? (sel1 ? PLAYER_3 : PLAYER_2) : (sel0 ? PLAYER_1 : PLAYER_0);
  endfunction

endpackage

// File: rtl/knockout_sched_match_scorer.sv
// Per-match game counters; flags the game that ends the match.
module match_scorer
  import knockout_pkg::*;
#(
  parameter int WINS_NEEDED = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               winner,
  input  logic               clear,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               decided,
  output logic               decided_winner
);

  localparam logic [SCORE_W-1:0] LAST_NEEDED = SCORE_W'(WINS_NEEDED - 1);

  logic [SCORE_W-1:0] winner_score;

  // The deciding game is recognised from the pre-increment score.
  always_comb begin
    winner_score   = winner ? score_b : score_a;
    decided        = accept && (winner_score == LAST_NEEDED);
    decided_winner = winner;
  end

  // Counters clear at match end so the deciding score is never shown.
  always_ff @(posedge clk) begin
    if (rst || clear || decided) begin
      score_a <= '0;
      score_b <= '0;
    end else if (accept) begin
      if (winner) score_b <= score_b + 1'b1;
      else        score_a <= score_a + 1'b1;
    end
  end

endmodule

// File: rtl/knockout_sched.sv
// Knockout bracket sequencer: semi 1, semi 2, final, then reports champion.
// Handshake: a game result is consumed in any cycle where match_req and
// game_valid are both high; game_winner is only meaningful in that cycle.
module knockout_sched
  import knockout_pkg::*;
#(
  parameter int WINS_NEEDED = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               game_valid,
  input  logic               game_winner,
  output logic               match_req,
  output logic [1:0]         match_id,
  output logic [1:0]         player_a,
  output logic [1:0]         player_b,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic               busy,
  output logic               done,
  output logic [1:0]         champion,
  output state_t             dbg_state
);

  state_t state, state_nx;
  logic   accept, clear, decided, decided_winner;

  assign busy      = (state == ST_SEMI1) || (state == ST_SEMI2) || (state == ST_FINAL);
  assign done      = (state == ST_DONE);
  assign match_req = busy;
  assign accept    = busy & game_valid;
  assign clear     = start & ~busy;
  assign dbg_state = state;

  match_scorer #(.WINS_NEEDED(WINS_NEEDED)) u_scorer (
    .clk            (clk),
    .rst            (rst),
    .accept         (accept),
    .winner         (game_winner),
    .clear          (clear),
    .score_a        (score_a),
    .score_b        (score_b),
    .decided        (decided),
    .decided_winner (decided_winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state: start only from IDLE/DONE, advance on each deciding game.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_SEMI1;
      ST_SEMI1:         if (decided) state_nx = ST_SEMI2;
      ST_SEMI2:         if (decided) state_nx = ST_FINAL;
      ST_FINAL:         if (decided) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  // Match identity and contenders decoded from state and earlier selects.
  always_comb begin
    match_id = MATCH_SEMI1;
    player_a = PLAYER_0;
    player_b = PLAYER_0;
    case (state)
      ST_SEMI1: begin
        match_id = MATCH_SEMI1;
        player_a = PLAYER_0;
        player_b = PLAYER_1;
      end
      ST_SEMI2: begin
        match_id = MATCH_SEMI2;
        player_a = PLAYER_2;
        player_b = PLAYER_3;
      end
      ST_FINAL: begin
        match_id = MATCH_FINAL;
        player_a = s0 ? PLAYER_1 : PLAYER_0;
        player_b = s1 ? PLAYER_3 : PLAYER_2;
      end
      ST_DONE: begin
        player_a = s0 ? PLAYER_1 : PLAYER_0;
        player_b = s1 ? PLAYER_3 : PLAYER_2;
      end
      default: ;
    endcase
  end

  // Bracket selects and champion: cleared on start, loaded by deciding games.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s0       <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      champion <= PLAYER_0;
    end else if (decided) begin
      case (state)
        ST_SEMI1: s0 <= decided_winner;
        ST_SEMI2: s1 <= decided_winner;
        ST_FINAL: begin
          s2       <= decided_winner;
          champion <= bracket_pick(s0, s1, decided_winner);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knockout_sched.sv
// Directed bench for knockout_sched with WINS_NEEDED = 2, 1 and 7 instances.
module tb_knockout_sched;
  import knockout_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic game_valid = 1'b0;
  logic game_winner = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Outputs of the three instances: u2 (WINS_NEEDED=2), u1 (=1), u7 (=7).
  logic       u2_match_req, u2_s0, u2_s1, u2_s2, u2_busy, u2_done;
  logic [1:0] u2_match_id, u2_player_a, u2_player_b, u2_champion;
  logic [2:0] u2_score_a, u2_score_b;
  state_t     u2_state;
  logic       u1_match_req, u1_s0, u1_s1, u1_s2, u1_busy, u1_done;
  logic [1:0] u1_match_id, u1_player_a, u1_player_b, u1_champion;
  logic [2:0] u1_score_a, u1_score_b;
  state_t     u1_state;
  logic       u7_match_req, u7_s0, u7_s1, u7_s2, u7_busy, u7_done;
  logic [1:0] u7_match_id, u7_player_a, u7_player_b, u7_champion;
  logic [2:0] u7_score_a, u7_score_b;
  state_t     u7_state;

  logic [19:0] all2, all1, all7;
  assign all2 = {u2_match_req, u2_match_id, u2_player_a, u2_player_b, u2_score_a, u2_score_b,
                 u2_s0, u2_s1, u2_s2, u2_busy, u2_done, u2_champion};
  assign all1 = {u1_match_req, u1_match_id, u1_player_a, u1_player_b, u1_score_a, u1_score_b,
                 u1_s0, u1_s1, u1_s2, u1_busy, u1_done, u1_champion};
  assign all7 = {u7_match_req, u7_match_id, u7_player_a, u7_player_b, u7_score_a, u7_score_b,
                 u7_s0, u7_s1, u7_s2, u7_busy, u7_done, u7_champion};

  knockout_sched #(.WINS_NEEDED(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .game_valid(game_valid), .game_winner(game_winner),
    .match_req(u2_match_req), .match_id(u2_match_id), .player_a(u2_player_a),
    .player_b(u2_player_b), .score_a(u2_score_a), .score_b(u2_score_b), .s0(u2_s0),
    .s1(u2_s1), .s2(u2_s2), .busy(u2_busy), .done(u2_done), .champion(u2_champion),
    .dbg_state(u2_state));

  knockout_sched #(.WINS_NEEDED(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .game_valid(game_valid), .game_winner(game_winner),
    .match_req(u1_match_req), .match_id(u1_match_id), .player_a(u1_player_a),
    .player_b(u1_player_b), .score_a(u1_score_a), .score_b(u1_score_b), .s0(u1_s0),
    .s1(u1_s1), .s2(u1_s2), .busy(u1_busy), .done(u1_done), .champion(u1_champion),
    .dbg_state(u1_state));

  knockout_sched #(.WINS_NEEDED(7)) u7 (
    .clk(clk), .rst(rst), .start(start), .game_valid(game_valid), .game_winner(game_winner),
    .match_req(u7_match_req), .match_id(u7_match_id), .player_a(u7_player_a),
    .player_b(u7_player_b), .score_a(u7_score_a), .score_b(u7_score_b), .s0(u7_s0),
    .s1(u7_s1), .s2(u7_s2), .busy(u7_busy), .done(u7_done), .champion(u7_champion),
    .dbg_state(u7_state));

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1ns after the rising edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play(input logic w);
    game_valid  = 1'b1;
    game_winner = w;
    tick();
    game_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; game_valid = 1'b0; game_winner = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_checks++; if (all2 !== 20'd0) begin n_fail++; $display("FAIL reset_outputs_w2 got %h want 0", all2); end
    n_checks++; if (all1 !== 20'd0) begin n_fail++; $display("FAIL reset_outputs_w1 got %h want 0", all1); end
    n_checks++; if (all7 !== 20'd0) begin n_fail++; $display("FAIL reset_outputs_w7 got %h want 0", all7); end
    n_checks++; if (u2_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", u2_state, ST_IDLE); end
    game_valid = 1'b1; game_winner = 1'b1;
    tick();
    game_valid = 1'b0;
    n_checks++; if (all2 !== 20'd0 || u2_state !== ST_IDLE) begin n_fail++; $display("FAIL idle_game_dropped got %h/%0d want 0/0", all2, u2_state); end
  endtask

  task automatic test_bracket_w2();
    do_start();
    n_checks++; if ({u2_busy, u2_match_req, u2_match_id, u2_player_a, u2_player_b} !== {1'b1, 1'b1, 2'd0, 2'd0, 2'd1}) begin n_fail++; $display("FAIL w2_start got busy=%b req=%b id=%0d a=%0d b=%0d want 1 1 0 0 1", u2_busy, u2_match_req, u2_match_id, u2_player_a, u2_player_b); end
    play(1'b0);
    n_checks++; if ({u2_score_a, u2_score_b} !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL w2_semi1_score got %0d/%0d want 1/0", u2_score_a, u2_score_b); end
    play(1'b0);
    n_checks++; if ({u2_match_id, u2_s0, u2_score_a, u2_score_b, u2_player_a, u2_player_b} !== {2'd1, 1'b0, 3'd0, 3'd0, 2'd2, 2'd3}) begin n_fail++; $display("FAIL w2_semi1_decided got id=%0d s0=%b sc=%0d/%0d a=%0d b=%0d want 1 0 0/0 2 3", u2_match_id, u2_s0, u2_score_a, u2_score_b, u2_player_a, u2_player_b); end
    play(1'b1);
    n_checks++; if ({u2_score_a, u2_score_b} !== {3'd0, 3'd1}) begin n_fail++; $display("FAIL w2_semi2_score_b got %0d/%0d want 0/1", u2_score_a, u2_score_b); end
    play(1'b0);
    n_checks++; if ({u2_score_a, u2_score_b, u2_match_id} !== {3'd1, 3'd1, 2'd1}) begin n_fail++; $display("FAIL w2_semi2_tied got %0d/%0d id=%0d want 1/1 id=1", u2_score_a, u2_score_b, u2_match_id); end
    play(1'b1);
    n_checks++; if ({u2_match_id, u2_s1, u2_player_a, u2_player_b, u2_score_a, u2_score_b} !== {2'd2, 1'b1, 2'd0, 2'd3, 3'd0, 3'd0}) begin n_fail++; $display("FAIL w2_final_pairing got id=%0d s1=%b a=%0d b=%0d sc=%0d/%0d want 2 1 0 3 0/0", u2_match_id, u2_s1, u2_player_a, u2_player_b, u2_score_a, u2_score_b); end
    play(1'b1);
    n_checks++; if ({u2_score_b, u2_busy, u2_done} !== {3'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL w2_final_score got sb=%0d busy=%b done=%b want 1 1 0", u2_score_b, u2_busy, u2_done); end
    play(1'b1);
    n_checks++; if ({u2_done, u2_busy, u2_match_req} !== 3'b100) begin n_fail++; $display("FAIL w2_done_flags got %b%b%b want 100", u2_done, u2_busy, u2_match_req); end
    n_checks++; if ({u2_s0, u2_s1, u2_s2} !== 3'b011) begin n_fail++; $display("FAIL w2_selects got %b%b%b want 011", u2_s0, u2_s1, u2_s2); end
    n_checks++; if (u2_champion !== 2'd3) begin n_fail++; $display("FAIL w2_champion got %0d want 3", u2_champion); end
    n_checks++; if ({u2_player_a, u2_player_b, u2_score_a, u2_score_b} !== {2'd0, 2'd3, 3'd0, 3'd0}) begin n_fail++; $display("FAIL w2_done_hold got a=%0d b=%0d sc=%0d/%0d want 0 3 0/0", u2_player_a, u2_player_b, u2_score_a, u2_score_b); end
  endtask

  task automatic test_done_ignore_and_restart();
    play(1'b0);
    n_checks++; if ({u2_done, u2_champion, u2_s0, u2_s1, u2_s2, u2_score_a} !== {1'b1, 2'd3, 3'b011, 3'd0} || u2_state !== ST_DONE) begin n_fail++; $display("FAIL done_game_dropped got done=%b champ=%0d sel=%b%b%b sa=%0d st=%0d want 1 3 011 0 4", u2_done, u2_champion, u2_s0, u2_s1, u2_s2, u2_score_a, u2_state); end
    start = 1'b1; game_valid = 1'b1; game_winner = 1'b1;
    tick();
    start = 1'b0; game_valid = 1'b0;
    n_checks++; if ({u2_match_id, u2_busy, u2_s0, u2_s1, u2_s2, u2_score_a, u2_score_b, u2_champion} !== {2'd0, 1'b1, 3'b000, 3'd0, 3'd0, 2'd0}) begin n_fail++; $display("FAIL restart_clear got id=%0d busy=%b sel=%b%b%b sc=%0d/%0d champ=%0d want 0 1 000 0/0 0", u2_match_id, u2_busy, u2_s0, u2_s1, u2_s2, u2_score_a, u2_score_b, u2_champion); end
    play(1'b0); play(1'b0); play(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({u2_score_a, u2_match_id} !== {3'd1, 2'd1} || u2_state !== ST_SEMI2) begin n_fail++; $display("FAIL busy_start_ignored got sa=%0d id=%0d st=%0d want 1 1 2", u2_score_a, u2_match_id, u2_state); end
    play(1'b0);
    n_checks++; if ({u2_match_id, u2_player_a, u2_player_b} !== {2'd2, 2'd0, 2'd2}) begin n_fail++; $display("FAIL restart_final_pair got id=%0d a=%0d b=%0d want 2 0 2", u2_match_id, u2_player_a, u2_player_b); end
    play(1'b0); play(1'b0);
    n_checks++; if ({u2_done, u2_champion, u2_s0, u2_s1, u2_s2} !== {1'b1, 2'd0, 3'b000}) begin n_fail++; $display("FAIL restart_champion got done=%b champ=%0d sel=%b%b%b want 1 0 000", u2_done, u2_champion, u2_s0, u2_s1, u2_s2); end
  endtask

  task automatic test_mid_final_reset();
    do_reset();
    do_start();
    play(1'b0); play(1'b0); play(1'b0); play(1'b0); play(1'b0);
    n_checks++; if ({u2_match_id, u2_score_a} !== {2'd2, 3'd1}) begin n_fail++; $display("FAIL midfinal_setup got id=%0d sa=%0d want 2 1", u2_match_id, u2_score_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (all2 !== 20'd0 || u2_state !== ST_IDLE) begin n_fail++; $display("FAIL midfinal_reset got %h/%0d want 0/0", all2, u2_state); end
    play(1'b1);
    n_checks++; if (all2 !== 20'd0 || u2_state !== ST_IDLE) begin n_fail++; $display("FAIL post_reset_game got %h/%0d want 0/0", all2, u2_state); end
  endtask

  task automatic test_back_to_back_w1();
    do_reset();
    do_start();
    n_checks++; if (u1_match_id !== 2'd0 || u1_match_req !== 1'b1) begin n_fail++; $display("FAIL w1_start got id=%0d req=%b want 0 1", u1_match_id, u1_match_req); end
    game_valid = 1'b1; game_winner = 1'b1;
    tick();
    n_checks++; if ({u1_match_id, u1_s0, u1_match_req} !== {2'd1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL w1_semi1 got id=%0d s0=%b req=%b want 1 1 1", u1_match_id, u1_s0, u1_match_req); end
    game_winner = 1'b0;
    tick();
    n_checks++; if ({u1_match_id, u1_s1, u1_player_a, u1_player_b} !== {2'd2, 1'b0, 2'd1, 2'd2}) begin n_fail++; $display("FAIL w1_semi2 got id=%0d s1=%b a=%0d b=%0d want 2 0 1 2", u1_match_id, u1_s1, u1_player_a, u1_player_b); end
    tick();
    game_valid = 1'b0;
    n_checks++; if ({u1_done, u1_champion, u1_s0, u1_s1, u1_s2} !== {1'b1, 2'd1, 3'b100}) begin n_fail++; $display("FAIL w1_champion got done=%b champ=%0d sel=%b%b%b want 1 1 100", u1_done, u1_champion, u1_s0, u1_s1, u1_s2); end
  endtask

  task automatic test_w7_no_wrap();
    do_reset();
    do_start();
    for (int i = 0; i < 6; i++) begin
      play(1'b0);
      play(1'b1);
    end
    n_checks++; if ({u7_score_a, u7_score_b, u7_match_id} !== {3'd6, 3'd6, 2'd0}) begin n_fail++; $display("FAIL w7_six_all got %0d/%0d id=%0d want 6/6 0", u7_score_a, u7_score_b, u7_match_id); end
    play(1'b0);
    n_checks++; if ({u7_match_id, u7_s0, u7_score_a, u7_score_b} !== {2'd1, 1'b0, 3'd0, 3'd0}) begin n_fail++; $display("FAIL w7_seventh_win got id=%0d s0=%b sc=%0d/%0d want 1 0 0/0", u7_match_id, u7_s0, u7_score_a, u7_score_b); end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_bracket_w2();
    test_done_ignore_and_restart();
    test_mid_final_reset();
    test_back_to_back_w1();
    test_w7_no_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
